// File: rtl/product_accumulator.sv
// Product accumulator: sums a burst of signed products into a saturating wide
// accumulator and presents the total on a valid/ready output.
module product_accumulator #(
    parameter int unsigned PW   = 64,
    parameter int unsigned AW   = 72,
    parameter int unsigned CNTW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [CNTW-1:0] len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PW-1:0]   in_product,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_acc,
    output logic            out_sat,
    output logic [CNTW-1:0] out_count,
    output logic            busy
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    localparam logic [AW-1:0]   AccMax = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0]   AccMin = {1'b1, {(AW-1){1'b0}}};
    localparam logic [CNTW-1:0] CntOne = {{(CNTW-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CNTW-1:0] rem_q, rem_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            sat_q, sat_d;

    logic            handshake;
    logic [AW:0]     sum_wide;
    logic [AW-1:0]   sum_sat;
    logic            sum_ovf;

    assign handshake = in_valid & in_ready;

    // One guard bit above AW: overflow shows as the top two bits disagreeing.
    assign sum_wide = {acc_q[AW-1], acc_q}
                    + {{(AW+1-PW){in_product[PW-1]}}, in_product};

    // Clamp the guarded sum back into AW bits, toward the sign of the true result.
    always_comb begin
        sum_ovf = sum_wide[AW] ^ sum_wide[AW-1];
        sum_sat = sum_wide[AW-1:0];
        if (sum_ovf) begin
            sum_sat = sum_wide[AW] ? AccMin : AccMax;
        end
    end

    // Next-state and datapath update; every register holds unless a branch moves it.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        count_d = count_q;
        sat_d   = sat_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    count_d = '0;
                    rem_d   = len;
                    state_d = (len == '0) ? StDone : StAccum;
                end
            end
            StAccum: begin
                if (handshake) begin
                    acc_d   = sum_sat;
                    sat_d   = sat_q | sum_ovf;
                    count_d = count_q + CntOne;
                    rem_d   = rem_q - CntOne;
                    if (rem_q == CntOne) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // start is deliberately ignored here, even alongside out_ready.
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            rem_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = (state_q == StAccum);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StAccum) || (state_q == StDone);
    assign out_acc   = acc_q;
    assign out_sat   = sat_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: a 72-bit and a 64-bit accumulator
// share one stimulus stream; expected totals are queued per burst and popped on out_valid.
module tb_product_accumulator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [63:0] in_product;
    logic        out_ready;

    logic        in_ready, out_valid, out_sat, busy;
    logic [71:0] out_acc;
    logic [7:0]  out_count;
    logic        in_ready64, out_valid64, out_sat64, busy64;
    logic [63:0] out_acc64;
    logic [7:0]  out_count64;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [71:0] acc72;
        logic        sat72;
        logic [63:0] acc64;
        logic        sat64;
        logic [7:0]  count;
    } exp_t;

    exp_t sb[$];

    logic signed [127:0] m72, m64;
    logic                s72, s64;
    logic [7:0]          mcnt;

    product_accumulator #(.PW(64), .AW(72), .CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_sat(out_sat), .out_count(out_count), .busy(busy)
    );

    product_accumulator #(.PW(64), .AW(64), .CNTW(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready64), .in_product(in_product),
        .out_valid(out_valid64), .out_ready(out_ready), .out_acc(out_acc64),
        .out_sat(out_sat64), .out_count(out_count64), .busy(busy64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference saturating add at an arbitrary width using 128-bit arithmetic.
    task automatic ref_add(input logic signed [127:0] a, input logic signed [63:0] p,
                           input int aw, output logic signed [127:0] r, output logic ovf);
        logic signed [127:0] one;
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        logic signed [127:0] s;
        one = 128'sd1;
        hi  = (one <<< (aw - 1)) - one;
        lo  = -(one <<< (aw - 1));
        s   = a + p;
        ovf = 1'b0;
        r   = s;
        if (s > hi) begin r = hi; ovf = 1'b1; end
        if (s < lo) begin r = lo; ovf = 1'b1; end
    endtask

    task automatic begin_burst(input logic [7:0] n);
        m72 = '0; m64 = '0; s72 = 1'b0; s64 = 1'b0; mcnt = '0;
        len   = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic model_push();
        exp_t e;
        e.acc72 = m72[71:0];
        e.sat72 = s72;
        e.acc64 = m64[63:0];
        e.sat64 = s64;
        e.count = mcnt;
        sb.push_back(e);
    endtask

    // Offer one product and hold it until the handshake edge has passed.
    task automatic send(input logic signed [63:0] p);
        int n;
        logic o;
        in_valid   = 1'b1;
        in_product = p;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_ready got in_ready=%0b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        ref_add(m72, p, 72, m72, o); s72 = s72 | o;
        ref_add(m64, p, 64, m64, o); s64 = s64 | o;
        mcnt = mcnt + 8'd1;
    endtask

    task automatic take_result(input string name);
        exp_t e;
        int n;
        n = 0;
        while (!(out_valid && out_valid64) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!(out_valid && out_valid64) || sb.size() == 0) begin
            errors++;
            $display("FAIL %s_valid got %0b/%0b want 1/1 (queued %0d)", name,
                     out_valid, out_valid64, sb.size());
        end else begin
            e = sb.pop_front();
            checks++;
            if (out_acc !== e.acc72) begin
                errors++;
                $display("FAIL %s_acc72 got %0d want %0d", name, $signed(out_acc), $signed(e.acc72));
            end
            checks++;
            if (out_sat !== e.sat72) begin
                errors++;
                $display("FAIL %s_sat72 got %0b want %0b", name, out_sat, e.sat72);
            end
            checks++;
            if (out_acc64 !== e.acc64) begin
                errors++;
                $display("FAIL %s_acc64 got %0d want %0d", name, $signed(out_acc64),
                         $signed(e.acc64));
            end
            checks++;
            if (out_sat64 !== e.sat64) begin
                errors++;
                $display("FAIL %s_sat64 got %0b want %0b", name, out_sat64, e.sat64);
            end
            checks++;
            if (out_count !== e.count || out_count64 !== e.count) begin
                errors++;
                $display("FAIL %s_count got %0d/%0d want %0d", name, out_count, out_count64,
                         e.count);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_release got valid=%0b busy=%0b want 0/0", name, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_product = '0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, out_sat, out_acc, out_count} !== '0) begin
            errors++;
            $display("FAIL reset got rdy=%0b vld=%0b busy=%0b sat=%0b acc=%0d cnt=%0d want 0",
                     in_ready, out_valid, busy, out_sat, out_acc, out_count);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic signed [63:0] p[5] = '{64'sd14, 64'sd10, 64'sd9, 64'sd6, -64'sd10};
        begin_burst(8'd5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_early_valid got %0b want 0 at product %0d", out_valid, i);
            end
            send(p[i]);
        end
        model_push();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_latency got out_valid=%0b want 1 right after last handshake",
                     out_valid);
        end
        take_result("b2b");
    endtask

    task automatic test_gaps();
        logic signed [63:0] p[3] = '{64'sd207, 64'sd0, -64'sd10};
        begin_burst(8'd3);
        for (int i = 0; i < 3; i++) begin
            send(p[i]);
            if (i < 2) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    checks++;
                    if (in_ready !== 1'b1 || out_count !== 8'(i + 1)) begin
                        errors++;
                        $display("FAIL gap_hold got ready=%0b count=%0d want 1/%0d",
                                 in_ready, out_count, i + 1);
                    end
                end
            end
        end
        model_push();
        take_result("gaps");
    endtask

    task automatic test_saturation();
        begin_burst(8'd2);
        send(64'sh4000_0000_0000_0000);
        send(64'sh4000_0000_0000_0000);
        model_push();
        take_result("sat");
        begin_burst(8'd1);
        send(-64'sd1);
        model_push();
        take_result("sat_clear");
    endtask

    task automatic test_empty_burst();
        begin_burst(8'd0);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL empty_state got vld=%0b rdy=%0b busy=%0b want 1/0/1",
                     out_valid, in_ready, busy);
        end
        model_push();
        take_result("empty");
    endtask

    task automatic test_done_hold();
        exp_t e;
        begin_burst(8'd1);
        send(64'sd3);
        model_push();
        e = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            start = 1'b1;
            len   = 8'd5;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_acc !== e.acc72 || out_count !== e.count
                || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL done_hold got vld=%0b acc=%0d cnt=%0d rdy=%0b want 1/%0d/%0d/0",
                         out_valid, out_acc, out_count, in_ready, e.acc72, e.count);
            end
        end
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_exit got vld=%0b busy=%0b want 0/0", out_valid, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_start_ignored got busy=%0b rdy=%0b want 0/0", busy, in_ready);
        end
    endtask

    task automatic test_reset_midburst();
        begin_burst(8'd4);
        send(64'sd5);
        send(64'sd6);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, out_sat, out_acc, out_count} !== '0
            || {in_ready64, out_valid64, busy64, out_acc64, out_count64} !== '0) begin
            errors++;
            $display("FAIL midreset got rdy=%0b vld=%0b busy=%0b acc=%0d cnt=%0d want 0",
                     in_ready, out_valid, busy, out_acc, out_count);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet got vld=%0b busy=%0b want 0/0", out_valid, busy);
            end
        end
        begin_burst(8'd1);
        send(64'sd7);
        model_push();
        take_result("after_reset");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_saturation();
        test_empty_burst();
        test_done_hold();
        test_reset_midburst();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
